// File: rtl/dds_nco_multi.sv
// rtl/dds_nco_multi.sv - multi-channel DDS with shadow/commit retune and quarter-wave sine LUT
// Optional amplitude scale stage is built when DDS_AMP_SCALE_EN is defined.
module dds_nco_multi #(
  parameter int                 N_CH     = 2,
  parameter int                 PHASE_W  = 32,
  parameter int                 ADDR_W   = 10,
  parameter int                 DATA_W   = 12,
  parameter int                 OUT_W    = 13,
  parameter logic [PHASE_W-1:0] FREQ_RST = 32'd42949673,
  parameter int                 CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk_50M,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  phase_clr,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_sel,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [PHASE_W-1:0]    cfg_wdata,
  input  logic                  cfg_commit,
  output logic [N_CH*OUT_W-1:0] dout,
  output logic                  dout_valid
);

  localparam int LUT_N  = 2 ** (ADDR_W - 2);
  localparam int LUT_AW = $clog2(LUT_N * DATA_W);
  localparam int FRAC   = 60;

  // Elaboration-time quarter-wave table: Taylor series in Q60 fixed point, rounded to nearest.
  function automatic logic [LUT_N*DATA_W-1:0] build_lut();
    logic [LUT_N*DATA_W-1:0] tbl;
    logic signed [127:0]     x, x2, term, acc, v;
    tbl = '0;
    for (int k = 0; k < LUT_N; k++) begin
      x    = (128'sh3243F6A8885A308D * $signed(128'(2 * k + 1))) >>> ADDR_W;
      x2   = (x * x) >>> FRAC;
      term = x;
      acc  = x;
      for (int n = 1; n < 16; n++) begin
        term = -(((term * x2) >>> FRAC) / $signed(128'((2 * n) * (2 * n + 1))));
        acc  = acc + term;
      end
      v = (acc * ((128'sd1 <<< (DATA_W - 1)) - 128'sd1) + (128'sd1 <<< (FRAC - 1))) >>> FRAC;
      tbl[k*DATA_W +: DATA_W] = v[DATA_W-1:0];
    end
    return tbl;
  endfunction

  localparam logic [LUT_N*DATA_W-1:0] LUT = build_lut();

  logic        [PHASE_W-1:0] r_acc     [N_CH];
  logic        [PHASE_W-1:0] r_freq    [N_CH];
  logic        [PHASE_W-1:0] r_freq_sh [N_CH];
  logic        [PHASE_W-1:0] r_off     [N_CH];
  logic        [PHASE_W-1:0] r_off_sh  [N_CH];
  logic        [ADDR_W-1:0]  r_a       [N_CH];
  logic        [DATA_W-1:0]  r_mag     [N_CH];
  logic        [N_CH-1:0]    r_neg;
  logic signed [OUT_W-1:0]   r_s       [N_CH];
  logic                      r_v1, r_v2, r_v3;
  logic        [ADDR_W-3:0]  w_idx     [N_CH];
  logic        [DATA_W-1:0]  w_lut     [N_CH];
  logic signed [OUT_W-1:0]   w_ext     [N_CH];
`ifdef DDS_AMP_SCALE_EN
  logic        [7:0]         r_amp     [N_CH];
  logic        [7:0]         r_amp_sh  [N_CH];
  logic signed [OUT_W-1:0]   r_y       [N_CH];
  logic signed [OUT_W+8:0]   w_prod    [N_CH];
  logic                      r_v4;
`endif

  // Commit uses the pre-edge shadow values, so a same-cycle write lands in shadow only.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        r_acc[i]     <= '0;
        r_freq[i]    <= FREQ_RST;
        r_freq_sh[i] <= FREQ_RST;
        r_off[i]     <= '0;
        r_off_sh[i]  <= '0;
`ifdef DDS_AMP_SCALE_EN
        r_amp[i]     <= 8'd128;
        r_amp_sh[i]  <= 8'd128;
`endif
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cfg_we && cfg_ch == CH_W'(i)) begin
          case (cfg_sel)
            2'd0:    r_freq_sh[i] <= cfg_wdata;
            2'd1:    r_off_sh[i]  <= cfg_wdata;
`ifdef DDS_AMP_SCALE_EN
            2'd2:    r_amp_sh[i]  <= cfg_wdata[7:0];
`endif
            default: ;
          endcase
        end
        if (cfg_commit) begin
          r_freq[i] <= r_freq_sh[i];
          r_off[i]  <= r_off_sh[i];
`ifdef DDS_AMP_SCALE_EN
          r_amp[i]  <= r_amp_sh[i];
`endif
        end
        if (phase_clr)
          r_acc[i] <= '0;
        else if (en)
          r_acc[i] <= r_acc[i] + r_freq[i];
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign w_idx[g] = r_a[g][ADDR_W-2] ? ~r_a[g][ADDR_W-3:0] : r_a[g][ADDR_W-3:0];
    assign w_lut[g] = LUT[LUT_AW'(int'(w_idx[g]) * DATA_W) +: DATA_W];
    assign w_ext[g] = {{(OUT_W-DATA_W){r_mag[g][DATA_W-1]}}, r_mag[g]};
`ifdef DDS_AMP_SCALE_EN
    assign w_prod[g] = (OUT_W+9)'(r_s[g]) * (OUT_W+9)'($signed({1'b0, r_amp[g]}));
    assign dout[g*OUT_W +: OUT_W] = r_y[g];
`else
    assign dout[g*OUT_W +: OUT_W] = r_s[g];
`endif
  end

  // Only the address bits of the offset phase are kept; lower bits never reach the LUT.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_neg <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_a[i]   <= '0;
        r_mag[i] <= '0;
        r_s[i]   <= '0;
      end
`ifdef DDS_AMP_SCALE_EN
      r_v4 <= 1'b0;
      for (int i = 0; i < N_CH; i++) r_y[i] <= '0;
`endif
    end else begin
      r_v1 <= en;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      for (int i = 0; i < N_CH; i++) begin
        if (en)
          r_a[i] <= ADDR_W'((r_acc[i] + r_off[i]) >> (PHASE_W - ADDR_W));
        if (r_v1) begin
          r_mag[i] <= w_lut[i];
          r_neg[i] <= r_a[i][ADDR_W-1];
        end
        if (r_v2)
          r_s[i] <= r_neg[i] ? -w_ext[i] : w_ext[i];
      end
`ifdef DDS_AMP_SCALE_EN
      r_v4 <= r_v3;
      for (int i = 0; i < N_CH; i++)
        if (r_v3) r_y[i] <= OUT_W'(w_prod[i] >>> 7);
`endif
    end
  end

`ifdef DDS_AMP_SCALE_EN
  assign dout_valid = r_v4;
`else
  assign dout_valid = r_v3;
`endif

endmodule

// File: tb/tb_dds_nco_multi.sv
// tb/tb_dds_nco_multi.sv - self-checking bench for dds_nco_multi against a sine-formula reference model
module tb_dds_nco_multi;
  localparam int OUT_W = 13;
`ifdef DDS_AMP_SCALE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk_50M = 1'b0;
  logic        rst_n, en, phase_clr, cfg_we, cfg_commit;
  logic [1:0]  cfg_sel;
  logic        cfg_ch;
  logic [31:0] cfg_wdata;
  logic [25:0] dout;
  logic        dout_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_acc[2], m_freq[2], m_freq_sh[2], m_off[2], m_off_sh[2];
  int          m_amp[2], m_amp_sh[2];
  bit          q_v[$];
  int          q_d0[$], q_d1[$];
  bit          m_valid;
  int          m_d0, m_d1;

  dds_nco_multi dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .en(en), .phase_clr(phase_clr),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ch(cfg_ch), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .dout(dout), .dout_valid(dout_valid)
  );

  always #10 clk_50M = ~clk_50M;

  function automatic int ref_sample(input logic [31:0] ph);
    int  a, k, m;
    real x;
    a = int'(ph >> 22);
    k = a % 256;
    if ((a / 256) % 2 == 1) k = 255 - k;
    x = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / 1024.0;
    m = $rtoi($floor(2047.0 * $sin(x) + 0.5));
    return (a >= 512) ? -m : m;
  endfunction

  function automatic int ref_out(input logic [31:0] ph, input int amp);
    int s;
    s = ref_sample(ph);
`ifdef DDS_AMP_SCALE_EN
    return $rtoi($floor(real'(s * amp) / 128.0));
`else
    return s + 0 * amp;
`endif
  endfunction

  function automatic int obs(input int c);
    int r;
    r = $signed(dout[c*OUT_W +: OUT_W]);
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_acc[c] = 0; m_freq[c] = 32'd42949673; m_freq_sh[c] = 32'd42949673;
      m_off[c] = 0; m_off_sh[c] = 0; m_amp[c] = 128; m_amp_sh[c] = 128;
    end
    q_v.delete(); q_d0.delete(); q_d1.delete();
    for (int i = 0; i < LAT; i++) begin q_v.push_back(0); q_d0.push_back(0); q_d1.push_back(0); end
    m_valid = 0; m_d0 = 0; m_d1 = 0;
  endtask

  task automatic model_edge(input bit e, clr, we, input int sel, ch, input logic [31:0] wd, input bit cm);
    int s0, s1, d0, d1;
    bit v;
    s0 = 0; s1 = 0;
    if (e) begin
      s0 = ref_out(m_acc[0] + m_off[0], m_amp[0]);
      s1 = ref_out(m_acc[1] + m_off[1], m_amp[1]);
    end
    q_v.push_back(e); q_d0.push_back(s0); q_d1.push_back(s1);
    for (int c = 0; c < 2; c++) begin
      if (clr) m_acc[c] = 0;
      else if (e) m_acc[c] = m_acc[c] + m_freq[c];
      if (cm) begin m_freq[c] = m_freq_sh[c]; m_off[c] = m_off_sh[c]; m_amp[c] = m_amp_sh[c]; end
    end
    if (we) begin
      if (sel == 0) m_freq_sh[ch] = wd;
      else if (sel == 1) m_off_sh[ch] = wd;
`ifdef DDS_AMP_SCALE_EN
      else if (sel == 2) m_amp_sh[ch] = int'(wd[7:0]);
`endif
    end
    v = q_v.pop_front(); d0 = q_d0.pop_front(); d1 = q_d1.pop_front();
    m_valid = v;
    if (v) begin m_d0 = d0; m_d1 = d1; end
  endtask

  task automatic cycle(input bit e, clr, we, input int sel, ch, input logic [31:0] wd, input bit cm);
    en = e; phase_clr = clr; cfg_we = we; cfg_sel = 2'(sel); cfg_ch = 1'(ch);
    cfg_wdata = wd; cfg_commit = cm;
    @(posedge clk_50M);
    model_edge(e, clr, we, sel, ch, wd, cm);
    @(negedge clk_50M);
  endtask

  task automatic run(input bit e);
    cycle(e, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int sel, ch, input logic [31:0] wd);
    cycle(0, 0, 1, sel, ch, wd, 0);
  endtask

  task automatic do_reset();
    rst_n = 0; en = 0; phase_clr = 0; cfg_we = 0; cfg_sel = 0; cfg_ch = 0;
    cfg_wdata = 0; cfg_commit = 0;
    repeat (2) @(negedge clk_50M);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (dout !== 26'd0) begin n_fail++; $display("FAIL reset_dout got %h want 0", dout); end
    n_tests++;
    if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", dout_valid); end
    run(0); run(0);
    n_tests++;
    if (dout_valid !== 1'b0 || dout !== 26'd0)
      begin n_fail++; $display("FAIL idle got v=%b %h want v=0 0", dout_valid, dout); end
  endtask

  task automatic test_static(input logic [31:0] off0, off1, input int w0, w1);
    do_reset();
    wr(0, 0, 0); wr(0, 1, 0); wr(1, 0, off0); wr(1, 1, off1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    for (int j = 0; j < 8; j++) begin
      run(1);
      n_tests++;
      if (j < LAT) begin
        if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL static_early[%0d] got v=%b want v=0", j, dout_valid); end
      end else if (dout_valid !== 1'b1 || obs(0) !== w0 || obs(1) !== w1) begin
        n_fail++;
        $display("FAIL static[%0d] got v=%b %0d %0d want v=1 %0d %0d", j, dout_valid, obs(0), obs(1), w0, w1);
      end
    end
  endtask

  task automatic test_defaults();
    do_reset();
    for (int j = 0; j < 110; j++) begin
      run(1);
      n_tests++;
      if (dout_valid !== m_valid || obs(0) !== m_d0 || obs(1) !== m_d1) begin
        n_fail++;
        $display("FAIL defaults[%0d] got v=%b %0d %0d want v=%b %0d %0d", j, dout_valid, obs(0), obs(1), m_valid, m_d0, m_d1);
      end
      if (j == LAT) begin
        n_tests++;
        if (dout_valid !== 1'b1 || obs(0) !== 6) begin n_fail++; $display("FAIL first_sample got v=%b %0d want v=1 6", dout_valid, obs(0)); end
      end
    end
  endtask

  task automatic test_retune();
    logic [31:0] f;
    f = $urandom;
    do_reset();
    for (int j = 0; j < 28; j++) begin
      case (j)
        4:       cycle(1, 0, 1, 0, 1, 0, 0);
        10:      cycle(1, 0, 0, 0, 0, 0, 1);
        16:      cycle(1, 0, 1, 0, 0, f, 1);
        22:      cycle(1, 0, 0, 0, 0, 0, 1);
        default: run(1);
      endcase
      n_tests++;
      if (dout_valid !== m_valid || obs(0) !== m_d0 || obs(1) !== m_d1) begin
        n_fail++;
        $display("FAIL retune[%0d] got v=%b %0d %0d want v=%b %0d %0d", j, dout_valid, obs(0), obs(1), m_valid, m_d0, m_d1);
      end
    end
  endtask

  task automatic test_en_toggle();
    int pulses;
    pulses = 0;
    do_reset();
    for (int j = 0; j < 8; j++) begin
      run(j == 0 || j == 2);
      if (dout_valid === 1'b1) pulses++;
      n_tests++;
      if (dout_valid !== m_valid || obs(0) !== m_d0 || obs(1) !== m_d1) begin
        n_fail++;
        $display("FAIL en_toggle[%0d] got v=%b %0d %0d want v=%b %0d %0d", j, dout_valid, obs(0), obs(1), m_valid, m_d0, m_d1);
      end
    end
    n_tests++;
    if (pulses !== 2) begin n_fail++; $display("FAIL en_pulses got %0d want 2", pulses); end
  endtask

  task automatic test_phase_clr();
    logic [31:0] off;
    off = $urandom;
    do_reset();
    wr(1, 0, off);
    cycle(0, 0, 0, 0, 0, 0, 1);
    repeat (5) run(1);
    cycle(0, 1, 0, 0, 0, 0, 0);
    for (int j = 0; j <= LAT; j++) run(1);
    n_tests++;
    if (dout_valid !== 1'b1 || obs(0) !== ref_out(off, 128) || obs(1) !== 6) begin
      n_fail++;
      $display("FAIL phase_clr got v=%b %0d %0d want v=1 %0d 6", dout_valid, obs(0), obs(1), ref_out(off, 128));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (6) run(1);
    @(posedge clk_50M);
    #3;
    rst_n = 0;
    #1;
    n_tests++;
    if (dout !== 26'd0 || dout_valid !== 1'b0)
      begin n_fail++; $display("FAIL reset_mid got v=%b %h want v=0 0", dout_valid, dout); end
    @(negedge clk_50M);
    rst_n = 1;
    model_reset();
    for (int j = 0; j < 5; j++) begin
      run(1);
      n_tests++;
      if (dout_valid !== m_valid || obs(0) !== m_d0 || obs(1) !== m_d1) begin
        n_fail++;
        $display("FAIL post_reset[%0d] got v=%b %0d %0d want v=%b %0d %0d", j, dout_valid, obs(0), obs(1), m_valid, m_d0, m_d1);
      end
    end
  endtask

  task automatic test_random();
    bit          e, clr, we, cm;
    int          sel, ch;
    logic [31:0] wd;
    do_reset();
    for (int j = 0; j < 400; j++) begin
      e   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      we  = ($urandom_range(0, 3) == 0);
      cm  = ($urandom_range(0, 15) == 0);
      sel = $urandom_range(0, 3);
      ch  = $urandom_range(0, 1);
      wd  = $urandom;
      cycle(e, clr, we, sel, ch, wd, cm);
      n_tests++;
      if (dout_valid !== m_valid || obs(0) !== m_d0 || obs(1) !== m_d1) begin
        n_fail++;
        $display("FAIL random[%0d] got v=%b %0d %0d want v=%b %0d %0d", j, dout_valid, obs(0), obs(1), m_valid, m_d0, m_d1);
      end
    end
  endtask

`ifdef DDS_AMP_SCALE_EN
  task automatic test_amp();
    do_reset();
    wr(0, 0, 0); wr(0, 1, 0); wr(1, 0, 32'd256 << 22); wr(1, 1, 32'd512 << 22);
    wr(2, 0, 255); wr(2, 1, 64);
    cycle(0, 0, 0, 0, 0, 0, 1);
    repeat (6) run(1);
    n_tests++;
    if (obs(0) !== 4078 || obs(1) !== -3)
      begin n_fail++; $display("FAIL amp got %0d %0d want 4078 -3", obs(0), obs(1)); end
    wr(2, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    repeat (6) run(1);
    n_tests++;
    if (obs(0) !== 0) begin n_fail++; $display("FAIL amp_zero got %0d want 0", obs(0)); end
  endtask
`endif

  initial begin
    test_reset();
    test_static(32'd0, 32'd256 << 22, 6, 2047);
    test_static(32'd512 << 22, 32'd768 << 22, -6, -2047);
    test_defaults();
    test_retune();
    test_en_toggle();
    test_phase_clr();
    test_reset_mid();
    test_random();
`ifdef DDS_AMP_SCALE_EN
    test_amp();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
